// File: rtl/warp_scheduler_if.sv
// warp_scheduler_if -- bundles the launch/retire/status handshake between the
// SIMT core and the two-warp scheduler.
//   Core -> scheduler : start_1/2, done_1/2, mem_pending_1/2, core_state[2:0]
//   Scheduler -> core : warp_select, stall, switch_pulse, all_done, quantum_cnt[7:0]
// Modports: master = core side (drives launch/status), slave = scheduler.
interface warp_scheduler_if;
  logic       start_1;
  logic       start_2;
  logic       done_1;
  logic       done_2;
  logic       mem_pending_1;
  logic       mem_pending_2;
  logic [2:0] core_state;
  logic       warp_select;
  logic       stall;
  logic       switch_pulse;
  logic       all_done;
  logic [7:0] quantum_cnt;

  modport master (
    output start_1, start_2, done_1, done_2, mem_pending_1, mem_pending_2, core_state,
    input  warp_select, stall, switch_pulse, all_done, quantum_cnt
  );

  modport slave (
    input  start_1, start_2, done_1, done_2, mem_pending_1, mem_pending_2, core_state,
    output warp_select, stall, switch_pulse, all_done, quantum_cnt
  );
endinterface

// File: rtl/warp_scheduler.sv
// warp_scheduler -- time-slices one SIMT core between two warps.
// A warp keeps the core until a safe point (memory wait, quantum expiry at an
// UPDATE boundary, or retirement); if the other warp is then eligible the
// core is stalled for one DRAIN cycle and ownership flips.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low; clears all state
//   bus   : warp_scheduler_if.slave (launch/retire/status in, select/stall/
//           switch_pulse/all_done/quantum_cnt out, all registered)
// Parameter QUANTUM (2..255): cycles a warp may hold the core before it is
// forced off at the next UPDATE.
module warp_scheduler #(
  parameter int unsigned QUANTUM = 16
) (
  input  logic             clk,
  input  logic             reset,
  warp_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  localparam logic [2:0] CS_WAIT   = 3'b100;
  localparam logic [2:0] CS_UPDATE = 3'b110;
  localparam logic [7:0] QMAX      = 8'(QUANTUM);

  state_e     state_q, state_d;
  logic       active_1_q, active_1_d;
  logic       active_2_q, active_2_d;
  logic       warp_select_q, warp_select_d;
  logic       stall_q, stall_d;
  logic       switch_pulse_q, switch_pulse_d;
  logic       all_done_q, all_done_d;
  logic [7:0] quantum_cnt_q, quantum_cnt_d;

  logic cur_done, cur_pending, cur_active, cur_retired;
  logic other_active, other_pending, other_eligible;
  logic quantum_up, safe_point;

  // Launch/retire bookkeeping; retirement wins over a simultaneous launch.
  always_comb begin
    active_1_d = active_1_q;
    active_2_d = active_2_q;
    if (bus.done_1)       active_1_d = 1'b0;
    else if (bus.start_1) active_1_d = 1'b1;
    if (bus.done_2)       active_2_d = 1'b0;
    else if (bus.start_2) active_2_d = 1'b1;
  end

  // View the two warps as "current" and "other" relative to warp_select.
  always_comb begin
    cur_done       = warp_select_q ? bus.done_2        : bus.done_1;
    cur_pending    = warp_select_q ? bus.mem_pending_2 : bus.mem_pending_1;
    cur_active     = warp_select_q ? active_2_q        : active_1_q;
    other_active   = warp_select_q ? active_1_q        : active_2_q;
    other_pending  = warp_select_q ? bus.mem_pending_1 : bus.mem_pending_2;
    other_eligible = other_active & ~other_pending;
    // A warp whose active bit has already cleared stays retired even if the
    // core drops done afterwards, so a pending hand-off is not lost.
    cur_retired    = cur_done | ~cur_active;
    quantum_up     = (quantum_cnt_q == QMAX);
    // All reasons OR together, so coincident reasons yield one switch.
    safe_point     = ((bus.core_state == CS_WAIT)   && cur_pending) ||
                     ((bus.core_state == CS_UPDATE) && quantum_up)  ||
                     cur_retired;
  end

  always_comb begin
    state_d        = state_q;
    warp_select_d  = warp_select_q;
    quantum_cnt_d  = quantum_cnt_q;
    stall_d        = 1'b0;
    switch_pulse_d = 1'b0;
    all_done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (active_1_q || active_2_q) begin
          state_d       = S_RUN;
          warp_select_d = ~active_1_q;  // warp 1 has priority on launch
          quantum_cnt_d = 8'd0;
        end
      end
      S_RUN: begin
        if (safe_point && cur_retired && !other_active) begin
          state_d    = S_FINISH;
          all_done_d = 1'b1;
        end else if (safe_point && other_eligible) begin
          state_d = S_DRAIN;
          stall_d = 1'b1;
        end else begin
          // Counter only advances while the warp keeps the core; it holds
          // its final value through DRAIN/FINISH.
          quantum_cnt_d = quantum_up ? quantum_cnt_q : quantum_cnt_q + 8'd1;
        end
      end
      S_DRAIN: begin
        // The switch is committed once DRAIN is entered; a retirement seen
        // now is handled by RUN on the following cycle.
        state_d        = S_RUN;
        warp_select_d  = ~warp_select_q;
        switch_pulse_d = 1'b1;
        quantum_cnt_d  = 8'd0;
      end
      S_FINISH: begin
        all_done_d = 1'b1;
        if (!bus.start_1 && !bus.start_2) begin
          state_d       = S_IDLE;
          all_done_d    = 1'b0;
          quantum_cnt_d = 8'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      active_1_q     <= 1'b0;
      active_2_q     <= 1'b0;
      warp_select_q  <= 1'b0;
      stall_q        <= 1'b0;
      switch_pulse_q <= 1'b0;
      all_done_q     <= 1'b0;
      quantum_cnt_q  <= 8'd0;
    end else begin
      state_q        <= state_d;
      active_1_q     <= active_1_d;
      active_2_q     <= active_2_d;
      warp_select_q  <= warp_select_d;
      stall_q        <= stall_d;
      switch_pulse_q <= switch_pulse_d;
      all_done_q     <= all_done_d;
      quantum_cnt_q  <= quantum_cnt_d;
    end
  end

  assign bus.warp_select  = warp_select_q;
  assign bus.stall        = stall_q;
  assign bus.switch_pulse = switch_pulse_q;
  assign bus.all_done     = all_done_q;
  assign bus.quantum_cnt  = quantum_cnt_q;

endmodule

// File: tb/tb_warp_scheduler.sv
// tb_warp_scheduler -- scenario tasks for the two-warp scheduler. Each cycle
// the expected output vector {warp_select, stall, switch_pulse, all_done,
// quantum_cnt} is queued when the stimulus is driven and popped/compared
// one time unit after the next rising edge.
module tb_warp_scheduler;
  localparam int Q = 16;
  localparam logic [2:0] CS_IDLE   = 3'b000;
  localparam logic [2:0] CS_FETCH  = 3'b001;
  localparam logic [2:0] CS_DECODE = 3'b010;
  localparam logic [2:0] CS_WAIT   = 3'b100;
  localparam logic [2:0] CS_EXEC   = 3'b101;
  localparam logic [2:0] CS_UPDATE = 3'b110;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [11:0] exp_q[$];

  warp_scheduler_if ifc();

  warp_scheduler #(.QUANTUM(Q)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] pk(logic ws, logic st, logic sp, logic ad, int cnt);
    return {ws, st, sp, ad, 8'(cnt)};
  endfunction

  function automatic logic [11:0] obs();
    return {ifc.warp_select, ifc.stall, ifc.switch_pulse, ifc.all_done, ifc.quantum_cnt};
  endfunction

  function automatic int sat(int k);
    return (k > Q) ? Q : k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(logic s1, logic s2, logic d1, logic d2, logic m1, logic m2,
                        logic [2:0] cs);
    ifc.start_1       = s1;
    ifc.start_2       = s2;
    ifc.done_1        = d1;
    ifc.done_2        = d2;
    ifc.mem_pending_1 = m1;
    ifc.mem_pending_2 = m2;
    ifc.core_state    = cs;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, CS_IDLE);
    reset = 1'b0;
    tick();
    tick();
    #3 reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [11:0] got, want;
    set_in(0, 0, 0, 0, 0, 0, CS_IDLE);
    #1 reset = 1'b0;
    exp_q.push_back(pk(0, 0, 0, 0, 0));
    #1;
    got = obs(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_fail++; $display("FAIL reset_async got=%03h want=%03h", got, want); end
    else $display("pass reset_async val=%03h", got);
    exp_q.push_back(pk(0, 0, 0, 0, 0));
    tick();
    got = obs(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_fail++; $display("FAIL reset_hold got=%03h want=%03h", got, want); end
    else $display("pass reset_hold val=%03h", got);
    #3 reset = 1'b1;
    exp_q.push_back(pk(0, 0, 0, 0, 0));
    tick();
    got = obs(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_fail++; $display("FAIL reset_release got=%03h want=%03h", got, want); end
    else $display("pass reset_release val=%03h", got);
  endtask

  // Warp 1 alone, retires at cycle 40: never switches, all_done the cycle after.
  task automatic test_single();
    logic [11:0] got, want;
    logic [2:0]  cs;
    localparam int D = 40;
    for (int c = 1; c <= D + 2; c++) begin
      case (c % 4)
        0:       cs = CS_FETCH;
        1:       cs = CS_DECODE;
        2:       cs = CS_EXEC;
        default: cs = CS_UPDATE;
      endcase
      set_in(c <= D + 1, 0, c >= D, 0, 0, 0, cs);
      if (c == 1)                want = pk(0, 0, 0, 0, 0);
      else if (c < D)            want = pk(0, 0, 0, 0, sat(c - 2));
      else if (c <= D + 1)       want = pk(0, 0, 0, 1, sat(D - 3));
      else                       want = pk(0, 0, 0, 0, 0);
      exp_q.push_back(want);
      tick();
      got = obs(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_fail++; $display("FAIL single c=%0d got=%03h want=%03h", c, got, want); end
      else $display("pass single c=%0d val=%03h", c, got);
    end
    ifc.done_1 = 1'b0;
  endtask

  // Both warps, no memory ops: UPDATE before expiry is ignored, UPDATE at
  // quantum_cnt==Q forces the switch.
  task automatic test_quantum();
    logic [11:0] got, want;
    do_reset();
    for (int c = 1; c <= 22; c++) begin
      set_in(1, 1, 0, 0, 0, 0, (c == 10 || c == 20) ? CS_UPDATE : CS_EXEC);
      if (c == 1)       want = pk(0, 0, 0, 0, 0);
      else if (c <= 19) want = pk(0, 0, 0, 0, sat(c - 2));
      else if (c == 20) want = pk(0, 1, 0, 0, Q);
      else if (c == 21) want = pk(1, 0, 1, 0, 0);
      else              want = pk(1, 0, 0, 0, 1);
      exp_q.push_back(want);
      tick();
      got = obs(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_fail++; $display("FAIL quantum c=%0d got=%03h want=%03h", c, got, want); end
      else $display("pass quantum c=%0d val=%03h", c, got);
    end
  endtask

  // Warp 1 hits WAIT with its request pending at quantum_cnt=3.
  task automatic test_mem_switch();
    logic [11:0] got, want;
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      set_in(1, 1, 0, 0, c >= 6, 0, (c == 6) ? CS_WAIT : CS_EXEC);
      if (c == 1)      want = pk(0, 0, 0, 0, 0);
      else if (c <= 5) want = pk(0, 0, 0, 0, c - 2);
      else if (c == 6) want = pk(0, 1, 0, 0, 3);
      else if (c == 7) want = pk(1, 0, 1, 0, 0);
      else             want = pk(1, 0, 0, 0, 1);
      exp_q.push_back(want);
      tick();
      got = obs(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_fail++; $display("FAIL mem_switch c=%0d got=%03h want=%03h", c, got, want); end
      else $display("pass mem_switch c=%0d val=%03h", c, got);
    end
  endtask

  // Warp 1 waits while warp 2 is also pending: no switch until warp 2 frees.
  task automatic test_pending_other();
    logic [11:0] got, want;
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      set_in(1, 1, 0, 0, c >= 4, c <= 5, (c >= 4 && c <= 6) ? CS_WAIT : CS_EXEC);
      if (c == 1)      want = pk(0, 0, 0, 0, 0);
      else if (c <= 5) want = pk(0, 0, 0, 0, c - 2);
      else if (c == 6) want = pk(0, 1, 0, 0, 3);
      else             want = pk(1, 0, 1, 0, 0);
      exp_q.push_back(want);
      tick();
      got = obs(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_fail++; $display("FAIL pending_other c=%0d got=%03h want=%03h", c, got, want); end
      else $display("pass pending_other c=%0d val=%03h", c, got);
    end
  endtask

  // Reset asserted mid-DRAIN clears outputs at once; relaunch picks warp 1.
  task automatic test_reset_drain();
    logic [11:0] got, want;
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      set_in(1, 1, 0, 0, c == 3, 0, (c == 3) ? CS_WAIT : CS_EXEC);
      if (c == 1)      want = pk(0, 0, 0, 0, 0);
      else if (c == 2) want = pk(0, 0, 0, 0, 0);
      else             want = pk(0, 1, 0, 0, 0);
      exp_q.push_back(want);
      tick();
      got = obs(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_fail++; $display("FAIL drain_setup c=%0d got=%03h want=%03h", c, got, want); end
      else $display("pass drain_setup c=%0d val=%03h", c, got);
    end
    #2 reset = 1'b0;
    exp_q.push_back(pk(0, 0, 0, 0, 0));
    #1;
    got = obs(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_fail++; $display("FAIL reset_in_drain got=%03h want=%03h", got, want); end
    else $display("pass reset_in_drain val=%03h", got);
    set_in(1, 1, 0, 0, 0, 0, CS_EXEC);
    #3 reset = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      if (c == 1) want = pk(0, 0, 0, 0, 0);
      else        want = pk(0, 0, 0, 0, c - 2);
      exp_q.push_back(want);
      tick();
      got = obs(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_fail++; $display("FAIL relaunch_after_reset c=%0d got=%03h want=%03h", c, got, want); end
      else $display("pass relaunch_after_reset c=%0d val=%03h", c, got);
    end
  endtask

  // Warp 1 retires while warp 2 is pending, hand-off once warp 2 frees, warp 2
  // retires -> FINISH, starts drop -> IDLE, relaunch goes to warp 1.
  task automatic test_finish_relaunch();
    logic [11:0] got, want;
    do_reset();
    for (int c = 1; c <= 13; c++) begin
      set_in((c <= 10) || (c >= 12), (c <= 10) || (c >= 12),
             (c >= 4 && c <= 11), (c >= 9 && c <= 11),
             0, (c >= 4 && c <= 5), CS_EXEC);
      case (c)
        1:       want = pk(0, 0, 0, 0, 0);
        2:       want = pk(0, 0, 0, 0, 0);
        3:       want = pk(0, 0, 0, 0, 1);
        4:       want = pk(0, 0, 0, 0, 2);
        5:       want = pk(0, 0, 0, 0, 3);
        6:       want = pk(0, 1, 0, 0, 3);
        7:       want = pk(1, 0, 1, 0, 0);
        8:       want = pk(1, 0, 0, 0, 1);
        9, 10:   want = pk(1, 0, 0, 1, 1);
        11, 12:  want = pk(1, 0, 0, 0, 0);
        default: want = pk(0, 0, 0, 0, 0);
      endcase
      exp_q.push_back(want);
      tick();
      got = obs(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_fail++; $display("FAIL finish_relaunch c=%0d got=%03h want=%03h", c, got, want); end
      else $display("pass finish_relaunch c=%0d val=%03h", c, got);
    end
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, CS_IDLE);
    test_reset();
    test_single();
    test_quantum();
    test_mem_switch();
    test_pending_other();
    test_reset_drain();
    test_finish_relaunch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/warp_scheduler.md
WARP_SCHEDULER -- requirements
Module: warp_scheduler

Interface
REQ-001 Parameter QUANTUM, default 16, max cycles a warp holds the core before a forced switch at an instruction boundary (range 2..255).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; low clears all state immediately.
REQ-004 start_1, start_2  in  1 each  level launch of warp 1 / warp 2.
REQ-005 done_1, done_2  in  1 each  warp 1 / warp 2 has retired (RET executed).
REQ-006 mem_pending_1, mem_pending_2  in  1 each  warp has outstanding LSU request.
REQ-007 core_state  in  3  pipeline state of selected warp: IDLE=000, FETCH=001, DECODE=010, REQUEST=011, WAIT=100, EXECUTE=101, UPDATE=110, DONE=111.
REQ-008 warp_select  out  1  0 = warp 1 owns core, 1 = warp 2.
REQ-009 stall  out  1  high during DRAIN; core holds pipeline state.
REQ-010 switch_pulse  out  1  one-cycle pulse on the cycle warp_select changes.
REQ-011 all_done  out  1  both launched warps retired.
REQ-012 quantum_cnt  out  8  cycles spent by current warp since last switch.

Function
REQ-013 active_n register: set when start_n=1 and done_n=0; cleared when done_n=1; eligible_n = active_n & ~mem_pending_n.
REQ-014 FSM states: IDLE, RUN, DRAIN, FINISH; all outputs registered.
REQ-015 IDLE: when active_1 or active_2 -> RUN, warp_select = 0 if active_1 else 1; no switch_pulse on this initial pick.
REQ-016 RUN: quantum_cnt increments by 1 per cycle, saturates at QUANTUM, never wraps.
REQ-017 Safe point = core_state WAIT with current mem_pending, or core_state UPDATE with quantum_cnt == QUANTUM, or current done_n = 1.
REQ-018 At safe point with other warp eligible -> DRAIN (stall=1 for exactly 1 cycle), then warp_select toggles, switch_pulse=1, quantum_cnt=0, -> RUN.
REQ-019 At safe point with other warp not eligible -> remain RUN, warp_select unchanged, counter stays saturated; switch re-evaluated every cycle while safe point holds.
REQ-020 Multiple safe-point reasons in one cycle produce a single switch.
REQ-021 Current warp done and other warp inactive -> FINISH; all_done=1.
REQ-022 Current warp done, other active but pending -> stay RUN until other eligible, then switch per REQ-018.
REQ-023 FINISH: all_done held high; -> IDLE when start_1=0 and start_2=0; all_done cleared on exit.
REQ-024 done_n arriving during DRAIN does not abort the switch; evaluated next cycle in RUN.
REQ-025 start_n deasserted while active_n=1 has no effect; only done_n or reset clears active_n.
REQ-026 Switch-to-switch latency is 2 cycles minimum (safe point cycle + DRAIN).

Reset
REQ-027 reset=0: state IDLE, warp_select=0, stall=0, switch_pulse=0, all_done=0, quantum_cnt=0, active_1=active_2=0, regardless of state (including mid-DRAIN).
REQ-028 Release of reset takes effect on the next rising clk edge; no output glitches while reset is low.

Verification
REQ-029 start_1=1 only, warp 1 issues instructions, done_1 at cycle 40 -> warp_select stays 0, no switch_pulse, all_done=1 cycle after done_1.
REQ-030 Both started, no memory ops, QUANTUM=16 -> first UPDATE with quantum_cnt=16 gives stall=1 one cycle, then warp_select=1, switch_pulse=1, quantum_cnt=0.
REQ-031 Warp 1 reaches WAIT with mem_pending_1=1, warp 2 eligible, quantum_cnt=3 -> switch at quantum_cnt=3, no quantum wait.
REQ-032 Warp 1 in WAIT, mem_pending_2=1 -> no switch; drop mem_pending_2 -> DRAIN next cycle, switch following cycle.
REQ-033 reset pulled low during DRAIN -> all outputs zero immediately; after release with both starts high, warp 1 selected.
REQ-034 Both warps done, then start_1=start_2=0 -> all_done falls, state IDLE; relaunch starts on warp 1.
